// File: rtl/motor_act_pkg.sv
// Shared definitions for the activation stream: mode encodings,
// default data format and configuration reset values.
package motor_act_pkg;

    localparam int unsigned W_DEF    = 21;
    localparam int unsigned I_DEF    = 7;
    localparam int unsigned N_CH_DEF = 4;

    typedef enum logic [1:0] {
        MODE_RELU  = 2'd0,
        MODE_CLIP  = 2'd1,
        MODE_LEAKY = 2'd2,
        MODE_PASS  = 2'd3
    } act_mode_e;

    localparam act_mode_e  CFG_MODE_RST  = MODE_RELU;
    localparam logic [3:0] CFG_SHIFT_RST = 4'd0;
    // Wide all-ones pattern; users take the low W-1 bits for the cap ceiling.
    localparam logic [63:0] CFG_CAP_RST  = '1;

endpackage

// File: rtl/motor_act_lane.sv
// One channel of the activation function. Purely combinational:
// produces the activated value and a flag when the clip ceiling bit.
module motor_act_lane
    import motor_act_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  act_mode_e    mode,
    input  logic [3:0]   shift,
    input  logic [W-2:0] cap,
    output logic [W-1:0] y,
    output logic         clip
);

    logic         neg;
    logic         pos;
    logic [W-1:0] shr;

    assign neg = x[W-1];
    assign pos = !neg && (x != '0);
    // Arithmetic shift floors toward minus infinity for negative inputs.
    assign shr = $unsigned($signed(x) >>> shift);

    // Select the activated value for the configured mode.
    always_comb begin
        y    = x;
        clip = 1'b0;
        case (mode)
            MODE_RELU: begin
                y = pos ? x : '0;
            end
            MODE_CLIP: begin
                if (!pos) begin
                    y = '0;
                end else if (x[W-2:0] > cap) begin
                    y    = {1'b0, cap};
                    clip = 1'b1;
                end
            end
            MODE_LEAKY: begin
                y = neg ? shr : x;
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule

// File: rtl/motor_act_stream.sv
// Streaming activation unit: N_CH fixed-point channels per beat,
// two-stage valid/ready pipeline (compute register, output register),
// with delivered-beat and clip counters.
module motor_act_stream
    import motor_act_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int I    = I_DEF,
    parameter int N_CH = N_CH_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [3:0]        cfg_shift,
    input  logic [W-2:0]      cfg_cap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic [31:0]       beat_cnt,
    output logic [31:0]       clip_cnt,
    output logic              busy
);

    act_mode_e          mode_q;
    logic [3:0]         shift_q;
    logic [W-2:0]       cap_q;

    logic               s1_valid;
    logic [N_CH*W-1:0]  s1_data;
    logic               s2_valid;
    logic [N_CH*W-1:0]  s2_data;

    logic               s2_load;
    logic               s1_adv;
    logic               accept;

    logic [N_CH*W-1:0]  lane_y;
    logic [N_CH-1:0]    lane_clip;
    logic [31:0]        clip_num;
    logic [32:0]        clip_sum;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_load;
    assign in_ready  = ap_rst_n && s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign busy      = s1_valid || s2_valid;

    // Lanes are only built for a legal fixed-point format (1 <= I <= W).
    if (I >= 1 && I <= W) begin : g_lanes
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            motor_act_lane #(
                .W (W)
            ) u_lane (
                .x     (in_data[k*W +: W]),
                .mode  (mode_q),
                .shift (shift_q),
                .cap   (cap_q),
                .y     (lane_y[k*W +: W]),
                .clip  (lane_clip[k])
            );
        end
    end else begin : g_no_lanes
        assign lane_y    = '0;
        assign lane_clip = '0;
    end

    // Number of channels clipped in the beat currently presented.
    always_comb begin
        clip_num = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            clip_num = clip_num + {31'b0, lane_clip[k]};
        end
        clip_sum = {1'b0, clip_cnt} + {1'b0, clip_num};
    end

    // Configuration registers; a write affects beats accepted from the next cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mode_q  <= CFG_MODE_RST;
            shift_q <= CFG_SHIFT_RST;
            cap_q   <= CFG_CAP_RST[W-2:0];
        end else if (cfg_we) begin
            mode_q  <= act_mode_e'(cfg_mode);
            shift_q <= cfg_shift;
            cap_q   <= cfg_cap;
        end
    end

    // Stage 1: capture the activated beat whenever stage 1 can advance.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= lane_y;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    // Saturating counters: delivered beats and clipped channels.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_cnt <= '0;
            clip_cnt <= '0;
        end else begin
            if (s2_valid && out_ready && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (accept) begin
                clip_cnt <= clip_sum[32] ? '1 : clip_sum[31:0];
            end
        end
    end

endmodule
